// File: rtl/cla_share_arbiter.sv
// Round-robin arbiter sharing one external carry-lookahead adder between two requesters.
// Operands are registered toward the adder; the result is captured after one settle cycle.
module cla_share_arbiter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req_valid,
  input  logic [2*WIDTH-1:0] req_a,
  input  logic [2*WIDTH-1:0] req_b,
  input  logic [1:0]         req_cin,
  output logic [1:0]         req_ready,
  output logic [1:0]         rsp_valid,
  input  logic [1:0]         rsp_ready,
  output logic [WIDTH-1:0]   rsp_sum,
  output logic               rsp_cout,
  output logic [WIDTH-1:0]   adder_a,
  output logic [WIDTH-1:0]   adder_b,
  output logic               adder_cin,
  input  logic [WIDTH-1:0]   adder_sum,
  input  logic               adder_cout,
  output logic               busy
);

  typedef enum logic [1:0] {StIdle, StCalc, StResp} state_e;

  state_e             state_q;
  logic               last_grant_q;
  logic               grant_q;
  logic               win_valid;
  logic               winner;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;
  logic               sel_cin;

  // Winner is only meaningful in IDLE; on contention the requester not served last wins.
  always_comb begin
    win_valid = 1'b0;
    winner    = 1'b0;
    if (state_q == StIdle) begin
      unique case (req_valid)
        2'b01: begin
          win_valid = 1'b1;
          winner    = 1'b0;
        end
        2'b10: begin
          win_valid = 1'b1;
          winner    = 1'b1;
        end
        2'b11: begin
          win_valid = 1'b1;
          winner    = ~last_grant_q;
        end
        default: begin
          win_valid = 1'b0;
          winner    = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    sel_a   = winner ? req_a[WIDTH +: WIDTH] : req_a[0 +: WIDTH];
    sel_b   = winner ? req_b[WIDTH +: WIDTH] : req_b[0 +: WIDTH];
    sel_cin = winner ? req_cin[1] : req_cin[0];
  end

  always_comb begin
    req_ready = 2'b00;
    if (win_valid) begin
      req_ready = winner ? 2'b10 : 2'b01;
    end
    rsp_valid = 2'b00;
    if (state_q == StResp) begin
      rsp_valid = grant_q ? 2'b10 : 2'b01;
    end
    busy = (state_q != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      adder_a      <= '0;
      adder_b      <= '0;
      adder_cin    <= 1'b0;
      rsp_sum      <= '0;
      rsp_cout     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (win_valid) begin
            adder_a   <= sel_a;
            adder_b   <= sel_b;
            adder_cin <= sel_cin;
            grant_q   <= winner;
            state_q   <= StCalc;
          end
        end
        StCalc: begin
          rsp_sum  <= adder_sum;
          rsp_cout <= adder_cout;
          state_q  <= StResp;
        end
        StResp: begin
          if (rsp_ready[grant_q]) begin
            last_grant_q <= grant_q;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_share_arbiter.sv
// Self-checking bench for cla_share_arbiter: directed vectors, corner sequences and random traffic
// checked every cycle against a transaction-level model of the arbitration and arithmetic rules.
module tb_cla_share_arbiter;

  localparam int W = 16;

  logic           clk;
  logic           rst_n;
  logic [1:0]     req_valid;
  logic [2*W-1:0] req_a;
  logic [2*W-1:0] req_b;
  logic [1:0]     req_cin;
  logic [1:0]     req_ready;
  logic [1:0]     rsp_valid;
  logic [1:0]     rsp_ready;
  logic [W-1:0]   rsp_sum;
  logic           rsp_cout;
  logic [W-1:0]   adder_a;
  logic [W-1:0]   adder_b;
  logic           adder_cin;
  logic [W-1:0]   adder_sum;
  logic           adder_cout;
  logic           busy;

  cla_share_arbiter #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_cin    (req_cin),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_sum    (rsp_sum),
    .rsp_cout   (rsp_cout),
    .adder_a    (adder_a),
    .adder_b    (adder_b),
    .adder_cin  (adder_cin),
    .adder_sum  (adder_sum),
    .adder_cout (adder_cout),
    .busy       (busy)
  );

  // Stand-in for the external adder.
  assign {adder_cout, adder_sum} = {1'b0, adder_a} + {1'b0, adder_b} + {{W{1'b0}}, adder_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Transaction-level model: at most one operation in flight, with its age in cycles.
  bit         m_busy;
  int         m_age;
  int         m_req;
  logic [W:0] m_res;
  int         m_last;
  logic [1:0] m_acc;
  int         grant_log[$];

  typedef struct {
    int          r;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_age  = 0;
    m_req  = 0;
    m_res  = '0;
    m_last = 1;
    m_acc  = 2'b00;
  endtask

  // Called at the negedge: compare DUT outputs, then advance the model across the next posedge.
  task automatic model_cycle();
    logic [1:0] er;
    logic [1:0] ev;
    logic [W:0] aa;
    logic [W:0] bb;
    int         w;
    er = 2'b00;
    ev = 2'b00;
    w  = -1;
    if (!m_busy) begin
      if (req_valid == 2'b11) w = 1 - m_last;
      else if (req_valid[0]) w = 0;
      else if (req_valid[1]) w = 1;
      if (w >= 0) er[w] = 1'b1;
    end
    if (m_busy && m_age >= 1) ev[m_req] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("rsp_valid", 32'(rsp_valid), 32'(ev));
    if (ev != 2'b00) begin
      chk("rsp_sum", 32'(rsp_sum), 32'(m_res[W-1:0]));
      chk("rsp_cout", 32'(rsp_cout), 32'(m_res[W]));
    end
    m_acc = er;
    if (w >= 0) begin
      aa     = {1'b0, req_a[w*W +: W]};
      bb     = {1'b0, req_b[w*W +: W]};
      m_res  = aa + bb + {{W{1'b0}}, req_cin[w]};
      m_busy = 1'b1;
      m_age  = 0;
      m_req  = w;
    end else if (m_busy) begin
      if (m_age >= 1 && rsp_ready[m_req]) begin
        m_busy = 1'b0;
        m_last = m_req;
        grant_log.push_back(m_req);
      end else begin
        m_age++;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int r, input logic [15:0] a, input logic [15:0] b, input logic c);
    req_valid[r]    = 1'b1;
    req_a[r*W +: W] = a;
    req_b[r*W +: W] = b;
    req_cin[r]      = c;
  endtask

  task automatic do_op(input vec_t v);
    bit got;
    got = 1'b0;
    set_op(v.r, v.a, v.b, v.cin);
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid[v.r]) begin
        chk("vec_sum", 32'(rsp_sum), 32'(v.sum));
        chk("vec_cout", 32'(rsp_cout), 32'(v.cout));
        got = 1'b1;
      end
      model_cycle();
      @(posedge clk);
      #1;
      if (m_acc[v.r]) begin
        req_valid[v.r] = 1'b0;
        req_a[v.r*W +: W] = 16'hDEAD;  // winner's operands change during CALC
      end
    end
    if (!got) chk("vec_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{0, 16'h0003, 16'h0008, 1'b0, 16'h000B, 1'b0};
    vecs[1] = '{1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vecs[2] = '{1, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vecs[3] = '{0, 16'h0103, 16'h0103, 1'b0, 16'h0206, 1'b0};
    vecs[4] = '{1, 16'h0607, 16'h0C01, 1'b0, 16'h1208, 1'b0};
    vecs[5] = '{0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    vecs[6] = '{0, 16'h1234, 16'h0000, 1'b1, 16'h1235, 1'b0};

    rst_n     = 1'b0;
    req_valid = 2'b00;
    req_a     = '0;
    req_b     = '0;
    req_cin   = 2'b00;
    rsp_ready = 2'b11;
    model_reset();
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_adder_a", 32'(adder_a), 32'd0);
    chk("rst_rsp_sum", 32'(rsp_sum), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed vectors, one requester at a time.
    for (int i = 0; i < 7; i++) do_op(vecs[i]);
    for (int i = 0; i < 3; i++) step();

    // Both requesters valid from reset: grants must alternate starting with requester 0.
    do_reset();
    grant_log.delete();
    set_op(0, 16'h0103, 16'h0103, 1'b0);
    set_op(1, 16'h0607, 16'h0C01, 1'b0);
    for (int i = 0; i < 40 && grant_log.size() < 6; i++) step();
    chk("fair_count", 32'(grant_log.size()), 32'd6);
    for (int i = 0; i < grant_log.size(); i++) chk("fair_order", 32'(grant_log[i]), 32'(i % 2));
    req_valid = 2'b00;
    for (int i = 0; i < 4; i++) step();

    // Backpressure on requester 0 while requester 1 waits.
    rsp_ready = 2'b10;
    set_op(0, 16'h4321, 16'h1111, 1'b1);
    set_op(1, 16'h0F0F, 16'h00F1, 1'b0);
    begin
      int n;
      n = 0;
      while (!rsp_valid[0] && n < 10) begin
        step();
        if (m_acc[0]) req_valid[0] = 1'b0;
        n++;
      end
      chk("bp_rsp_rise", 32'(rsp_valid), 32'd1);
      for (int i = 0; i < 5; i++) step();
      chk("bp_held_busy", 32'(busy), 32'd1);
      rsp_ready = 2'b11;
      n = 0;
      while (!m_acc[1] && n < 10) begin
        step();
        n++;
      end
      chk("bp_req1_accept_delay", 32'(n), 32'd2);
      req_valid[1] = 1'b0;
    end
    for (int i = 0; i < 4; i++) step();

    // Reset asserted during CALC drops the operation.
    set_op(0, 16'h7777, 16'h1111, 1'b0);
    for (int i = 0; i < 5 && !m_acc[0]; i++) step();
    req_valid = 2'b00;
    chk("midrst_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_adder", 32'({adder_a, adder_b}), 32'd0);
    chk("midrst_cin", 32'(adder_cin), 32'd0);
    chk("midrst_rsp", 32'({rsp_valid, rsp_cout, rsp_sum}), 32'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step();
    do_op(vecs[0]);
    for (int i = 0; i < 3; i++) step();

    // Random traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      for (int r = 0; r < 2; r++) begin
        if (req_valid[r] && m_acc[r]) begin
          if ($urandom_range(0, 1) == 0) req_valid[r] = 1'b0;
          req_a[r*W +: W] = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
          req_b[r*W +: W] = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
          req_cin[r]      = 1'($urandom);
        end else if (!req_valid[r] && $urandom_range(0, 2) == 0) begin
          set_op(r, 16'($urandom), ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom),
                 1'($urandom));
        end
      end
      rsp_ready = 2'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
